buzzer_sequencer: RTL and testbench
===================================

Name: buzzer_sequencer

Overview:
Scheduler that shares the single board buzzer (beep pin) between three event sources, e.g. the debounced key flag pulses and a counter-wrap event. Each source has a fixed beep pattern of N tone bursts. Requests are latched, arbitrated by fixed priority, and played one pattern at a time. It replaces the free-running toggle-enable buzzer in the top level.

Parameters:
TONE_DIV, 56818, cycles per beep half-period (50 MHz / 880 gives 440 Hz); must be >= 1
ON_CYCLES, 5000000, length of one tone burst in clocks (100 ms); must be >= 1
OFF_CYCLES, 5000000, silence after each burst in clocks; must be >= 1
BEEPS0, 1, bursts played for source 0; range 1..15
BEEPS1, 2, bursts played for source 1; range 1..15
BEEPS2, 3, bursts played for source 2; range 1..15

Ports:
FPGA_CLK  in  1  single clock, 50 MHz
RESET_BUT  in  1  reset, asynchronous, active-low
req  in  3  single-cycle request pulses; bit i = source i
cancel  in  1  single-cycle pulse; aborts the current pattern and clears all pending requests
mute  in  1  level; forces beep to 0 without altering timing
beep  out  1  registered square wave to the buzzer pin
busy  out  1  high when state != IDLE
grant  out  2  index of the source being played; 0 when idle
pending  out  3  latched, not-yet-served requests

Behaviour:
- Reset (RESET_BUT=0, asynchronous): state=IDLE; beep, busy, grant and pending = 0; all counters = 0.
- Pending latch:
  - pending[i] is set the cycle after req[i]=1.
  - pending[i] is cleared on the edge where source i is granted.
  - A req[i] arriving while pending[i]=1 merges; it is not counted.
  - A req[i] arriving while source i is playing sets pending[i] again, so the pattern replays afterwards.
  - If a set and a clear of pending[i] occur on the same edge, the set wins.
- FSM states: IDLE, TONE_ON, TONE_OFF.
- IDLE:
  - If pending != 0, select the highest set bit (priority 2 > 1 > 0).
  - Load grant and beeps_left = BEEPSx.
  - Go to TONE_ON with timer = 0, tone counter = 0 and beep <= 1.
  - Otherwise stay in IDLE.
- TONE_ON:
  - Lasts exactly ON_CYCLES cycles.
  - Tone counter increments each cycle; at TONE_DIV-1 it wraps to 0 and beep toggles.
  - On the last cycle, go to TONE_OFF with beep <= 0 and beeps_left <= beeps_left-1.
- TONE_OFF:
  - Lasts exactly OFF_CYCLES cycles with beep = 0.
  - On the last cycle: if beeps_left = 0, go to IDLE and set grant <= 0.
  - Otherwise go to TONE_ON with beep <= 1 and tone counter = 0.
- After every pattern the FSM spends at least one cycle in IDLE (busy=0 for 1 cycle), even if requests are pending.
- Latency: req pulse at cycle t gives pending at t+1, then TONE_ON with beep=1 and busy=1 at t+2.
- mute=1: beep register is loaded with 0 each cycle; the internal tone phase and timers continue unchanged.
- cancel=1 in any state: next cycle state=IDLE, beep=0, grant=0, pending=000. A req in the same cycle as cancel is dropped.
- Counter widths:
  - timer is $clog2(max(ON_CYCLES, OFF_CYCLES)) bits.
  - tone counter is $clog2(TONE_DIV) bits, minimum 1.
  - beeps_left is 4 bits.
- No wrap of beeps_left occurs, because the decrement happens only when the value is >= 1.

Test Plan:
(bench parameters: TONE_DIV=2, ON_CYCLES=8, OFF_CYCLES=4, BEEPS0=1, BEEPS1=2, BEEPS2=3)
1. Single request: req=001 at cycle 0 -> pending=001 at cycle 1; busy=1, grant=0 at cycle 2; beep=1,1,0,0,1,1,0,0 over cycles 2-9; beep=0 over cycles 10-13; busy=0 at cycle 14.
2. Simultaneous requests: req=011 at cycle 0 -> grant=1 from cycle 2; two bursts starting at cycles 2 and 14; pending=001 throughout; IDLE at cycle 26 (busy=0); grant=0 and beep=1 at cycle 27; busy=0 at cycle 39.
3. Requests during playback: req=100 at cycle 0; req=001 at cycles 5 and 9 -> three bursts for source 2 ending at cycle 37; pending=001 (single, merged) from cycle 6; source 0 plays once starting at cycle 39.
4. Cancel: cancel at cycle 4 of scenario 1, with req=010 in the same cycle -> cycle 5: state IDLE, beep=0, busy=0, pending=000; nothing plays afterwards.
5. Mute: scenario 1 with mute=1 during cycles 3-6 -> beep=0 in cycles 4-7; beep=0 in cycle 8, then 0 in cycle 9 (phase preserved); busy timing identical to scenario 1.
6. Reset: RESET_BUT=0 asynchronously mid-TONE_ON during scenario 2 -> all outputs 0 immediately; after release, req=001 plays normally with the scenario 1 timing.

Source files
------------

// File: rtl/buzzer_sequencer.sv
// rtl/buzzer_sequencer.sv - shares one buzzer pin between three prioritised beep-pattern sources
module buzzer_sequencer #(
  parameter int TONE_DIV   = 56818,
  parameter int ON_CYCLES  = 5000000,
  parameter int OFF_CYCLES = 5000000,
  parameter int BEEPS0     = 1,
  parameter int BEEPS1     = 2,
  parameter int BEEPS2     = 3
) (
  input  logic       FPGA_CLK,
  input  logic       RESET_BUT,
  input  logic [2:0] req,
  input  logic       cancel,
  input  logic       mute,
  output logic       beep,
  output logic       busy,
  output logic [1:0] grant,
  output logic [2:0] pending
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int TONE_W  = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  localparam logic [TMR_W-1:0]  ON_LAST   = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0]  OFF_LAST  = TMR_W'(OFF_CYCLES - 1);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);
  localparam logic [3:0]        NB0       = 4'(BEEPS0);
  localparam logic [3:0]        NB1       = 4'(BEEPS1);
  localparam logic [3:0]        NB2       = 4'(BEEPS2);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TONE_ON  = 2'd1,
    TONE_OFF = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [TONE_W-1:0] tone_q, tone_d;
  logic              phase_q, phase_d;   // unmuted tone level; mute only masks the pin
  logic              beep_q, beep_d;
  logic [3:0]        beeps_q, beeps_d;
  logic [1:0]        grant_q, grant_d;
  logic [2:0]        pending_q, pending_d;
  logic [2:0]        clr;

  // Next-state logic: arbitration, burst/gap timing and tone generation
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    tone_d    = tone_q;
    phase_d   = phase_q;
    beeps_d   = beeps_q;
    grant_d   = grant_q;
    clr       = 3'b000;

    case (state_q)
      IDLE: begin
        if (pending_q != 3'b000) begin
          if (pending_q[2]) begin
            grant_d = 2'd2;
            beeps_d = NB2;
            clr     = 3'b100;
          end else if (pending_q[1]) begin
            grant_d = 2'd1;
            beeps_d = NB1;
            clr     = 3'b010;
          end else begin
            grant_d = 2'd0;
            beeps_d = NB0;
            clr     = 3'b001;
          end
          state_d = TONE_ON;
          timer_d = '0;
          tone_d  = '0;
          phase_d = 1'b1;
        end
      end
      TONE_ON: begin
        if (timer_q == ON_LAST) begin
          state_d = TONE_OFF;
          timer_d = '0;
          tone_d  = '0;
          phase_d = 1'b0;
          if (beeps_q != 4'd0) begin
            beeps_d = beeps_q - 4'd1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
          if (tone_q == TONE_LAST) begin
            tone_d  = '0;
            phase_d = ~phase_q;
          end else begin
            tone_d = tone_q + 1'b1;
          end
        end
      end
      TONE_OFF: begin
        if (timer_q == OFF_LAST) begin
          timer_d = '0;
          if (beeps_q == 4'd0) begin
            state_d = IDLE;
            grant_d = 2'd0;
          end else begin
            state_d = TONE_ON;
            tone_d  = '0;
            phase_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Cancel overrides everything, including a request in the same cycle
    if (cancel) begin
      state_d = IDLE;
      timer_d = '0;
      tone_d  = '0;
      phase_d = 1'b0;
      beeps_d = 4'd0;
      grant_d = 2'd0;
    end

    // New requests win over the grant-clear on the same edge
    pending_d = cancel ? 3'b000 : ((pending_q & ~clr) | req);
    beep_d    = phase_d & ~mute;
  end

  // State and datapath registers
  always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
    if (!RESET_BUT) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      tone_q    <= '0;
      phase_q   <= 1'b0;
      beep_q    <= 1'b0;
      beeps_q   <= 4'd0;
      grant_q   <= 2'd0;
      pending_q <= 3'b000;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      tone_q    <= tone_d;
      phase_q   <= phase_d;
      beep_q    <= beep_d;
      beeps_q   <= beeps_d;
      grant_q   <= grant_d;
      pending_q <= pending_d;
    end
  end

  assign beep    = beep_q;
  assign busy    = (state_q != IDLE);
  assign grant   = grant_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// tb/tb_buzzer_sequencer.sv - scoreboard bench for buzzer_sequencer
module tb_buzzer_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic       cancel = 1'b0;
  logic       mute = 1'b0;
  logic       beep, busy;
  logic [1:0] grant;
  logic [2:0] pending;

  always #5 clk = ~clk;

  buzzer_sequencer #(
    .TONE_DIV(2), .ON_CYCLES(8), .OFF_CYCLES(4),
    .BEEPS0(1), .BEEPS1(2), .BEEPS2(3)
  ) dut (
    .FPGA_CLK(clk), .RESET_BUT(rst_n), .req(req), .cancel(cancel), .mute(mute),
    .beep(beep), .busy(busy), .grant(grant), .pending(pending)
  );

  typedef struct packed {
    logic [7:0] cyc;
    logic       busy;
    logic       beep;
    logic [1:0] grant;
    logic [2:0] pending;
  } exp_t;

  exp_t  sb_q[$];
  int    total = 0;
  int    bad = 0;
  string scen = "init";

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic burst(input int c, input int s);
    return (c >= s) && (c < s + 8) && (((c - s) % 4) < 2);
  endfunction

  function automatic logic in_rng(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // Expected outputs for cycle c of scenario sc, taken from the hand-derived timelines
  function automatic exp_t exp_for(input int sc, input int c);
    exp_t e;
    e.cyc = 8'(c);
    e.busy = 1'b0; e.beep = 1'b0; e.grant = 2'd0; e.pending = 3'b000;
    case (sc)
      1, 5: begin
        e.busy    = in_rng(c, 2, 13);
        e.beep    = burst(c, 2) && !(sc == 5 && in_rng(c, 4, 7));
        e.pending = (c == 1) ? 3'b001 : 3'b000;
      end
      2: begin
        e.busy    = in_rng(c, 2, 25) || in_rng(c, 27, 38);
        e.beep    = burst(c, 2) || burst(c, 14) || burst(c, 27);
        e.grant   = in_rng(c, 2, 25) ? 2'd1 : 2'd0;
        e.pending = (c == 1) ? 3'b011 : (in_rng(c, 2, 26) ? 3'b001 : 3'b000);
      end
      3: begin
        e.busy    = in_rng(c, 2, 37) || in_rng(c, 39, 50);
        e.beep    = burst(c, 2) || burst(c, 14) || burst(c, 26) || burst(c, 39);
        e.grant   = in_rng(c, 2, 37) ? 2'd2 : 2'd0;
        e.pending = (c == 1) ? 3'b100 : (in_rng(c, 6, 38) ? 3'b001 : 3'b000);
      end
      4: begin
        e.busy    = in_rng(c, 2, 4);
        e.beep    = burst(c, 2) && (c <= 4);
        e.pending = (c == 1) ? 3'b001 : 3'b000;
      end
      default: ;
    endcase
    return e;
  endfunction

  // Drive scenario stimulus at negedges; expected output for the following cycle goes to the scoreboard
  task automatic run_scenario(input int sc, input int ncyc);
    scen = $sformatf("s%0d", sc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      req = 3'b000; cancel = 1'b0; mute = 1'b0;
      case (sc)
        1, 5: if (c == 0) req = 3'b001;
        2:    if (c == 0) req = 3'b011;
        3:    begin
                if (c == 0) req = 3'b100;
                if (c == 5 || c == 9) req = 3'b001;
              end
        4:    begin
                if (c == 0) req = 3'b001;
                if (c == 4) begin cancel = 1'b1; req = 3'b010; end
              end
        default: ;
      endcase
      if (sc == 5 && c >= 3 && c <= 6) mute = 1'b1;
      sb_q.push_back(exp_for(sc, c + 1));
    end
    @(negedge clk);
    req = 3'b000; cancel = 1'b0; mute = 1'b0;
  endtask

  // Compare DUT outputs just after each active edge against the scoreboard head
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val($sformatf("%s c%0d busy", scen, e.cyc), {7'd0, busy}, {7'd0, e.busy});
      check_val($sformatf("%s c%0d beep", scen, e.cyc), {7'd0, beep}, {7'd0, e.beep});
      check_val($sformatf("%s c%0d grant", scen, e.cyc), {6'd0, grant}, {6'd0, e.grant});
      check_val($sformatf("%s c%0d pending", scen, e.cyc), {5'd0, pending}, {5'd0, e.pending});
    end
  end

  initial begin
    #2;
    check_val("rst busy", {7'd0, busy}, 8'd0);
    check_val("rst beep", {7'd0, beep}, 8'd0);
    check_val("rst grant", {6'd0, grant}, 8'd0);
    check_val("rst pending", {5'd0, pending}, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_scenario(1, 16);
    run_scenario(2, 41);
    run_scenario(3, 53);
    run_scenario(4, 20);
    run_scenario(5, 16);

    // Asynchronous reset in the middle of a burst, beep currently high
    run_scenario(2, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst busy", {7'd0, busy}, 8'd0);
    check_val("arst beep", {7'd0, beep}, 8'd0);
    check_val("arst grant", {6'd0, grant}, 8'd0);
    check_val("arst pending", {5'd0, pending}, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_scenario(1, 16);

    repeat (3) @(posedge clk);
    #2;
    check_val("sb drain", 8'(sb_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
